// File: rtl/queue_motion.sv
// queue_motion: per-frame motion and game-state controller for the "queue" sprite.
// Turns button levels into walk/jump motion once per frame_tick and tracks the
// INITIAL/PLAYING game state. Outputs change only on frame_tick, except at reset.
// Optional build macro QUEUE_WRAP_EN: horizontal motion wraps at the screen edges
// instead of clamping. Vertical motion is the same in both builds.
module queue_motion #(
    parameter int unsigned START_X  = 320,
    parameter int unsigned X_MIN    = 30,
    parameter int unsigned X_MAX    = 609,
    parameter int unsigned Y_MIN    = 50,
    parameter int unsigned FLOOR_Y  = 429,
    parameter int unsigned STEP_X   = 2,
    parameter int unsigned JUMP_V   = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       game_over,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] posX,
    output logic [8:0] posY,
    output logic       state,
    output logic       animation_state,
    output logic       in_air
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned VW = 6;
    localparam int unsigned AW = 11;

    localparam logic signed [AW-1:0] X_MIN_S   = AW'(X_MIN);
    localparam logic signed [AW-1:0] X_MAX_S   = AW'(X_MAX);
    localparam logic signed [AW-1:0] Y_MIN_S   = AW'(Y_MIN);
    localparam logic signed [AW-1:0] FLOOR_Y_S = AW'(FLOOR_Y);
    localparam logic signed [AW-1:0] STEP_X_S  = AW'(STEP_X);
    localparam logic signed [VW-1:0] JUMP_V_S  = VW'(JUMP_V);
    localparam logic signed [VW-1:0] GRAV_S    = VW'(GRAVITY);
    localparam logic signed [VW-1:0] VY_FLOOR  = -$signed(VW'(MAX_FALL));
    localparam logic signed [VW-1:0] VY_ZERO   = '0;

    typedef enum logic {
        G_INITIAL = 1'b0,
        G_PLAYING = 1'b1
    } game_e;

    typedef enum logic [1:0] {
        M_GROUND  = 2'd0,
        M_RISING  = 2'd1,
        M_FALLING = 2'd2
    } motion_e;

    game_e                game_q,       game_d;
    motion_e              motion_q,     motion_d;
    logic [XW-1:0]        pos_x_q,      pos_x_d;
    logic [YW-1:0]        pos_y_q,      pos_y_d;
    logic signed [VW-1:0] vy_q,         vy_d;
    logic                 face_q,       face_d;
    logic                 in_air_q,     in_air_d;
    logic                 start_pend_q, start_pend_d;
    logic                 go_pend_q,    go_pend_d;
    logic                 jump_armed_q, jump_armed_d;

    logic                 move_l;
    logic                 move_r;
    logic signed [AW-1:0] x_cur;
    logic signed [AW-1:0] x_cand;
    logic signed [AW-1:0] y_next;
    logic signed [VW-1:0] vy_dec;
    logic signed [VW-1:0] vy_new;

    // Next-state: pending-flag latching, game FSM, horizontal and vertical motion
    always_comb begin
        game_d       = game_q;
        motion_d     = motion_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        vy_d         = vy_q;
        face_d       = face_q;
        in_air_d     = in_air_q;
        start_pend_d = start_pend_q | start;
        go_pend_d    = go_pend_q | game_over;
        jump_armed_d = jump_armed_q;

        move_l = btn_left & ~btn_right;
        move_r = btn_right & ~btn_left;
        x_cur  = $signed({1'b0, pos_x_q});
        x_cand = x_cur;
        if (move_l) begin
            x_cand = x_cur - STEP_X_S;
        end else if (move_r) begin
            x_cand = x_cur + STEP_X_S;
        end

        y_next = $signed({2'b00, pos_y_q}) - {{(AW-VW){vy_q[VW-1]}}, vy_q};
        vy_dec = vy_q - GRAV_S;
        vy_new = (vy_dec < VY_FLOOR) ? VY_FLOOR : vy_dec;

        if (frame_tick) begin
            // Flags seen at this tick are consumed; a pulse on this very cycle waits for the next tick
            start_pend_d = start;
            go_pend_d    = game_over;
            if (!btn_jump) begin
                jump_armed_d = 1'b1;
            end

            case (game_q)
                G_INITIAL: begin
                    if (start_pend_q) begin
                        game_d   = G_PLAYING;
                        pos_x_d  = XW'(START_X);
                        pos_y_d  = YW'(FLOOR_Y);
                        vy_d     = '0;
                        motion_d = M_GROUND;
                        in_air_d = 1'b0;
                    end
                end
                default: begin
                    if (go_pend_q) begin
                        game_d   = G_INITIAL;
                        motion_d = M_GROUND;
                        vy_d     = '0;
                        in_air_d = 1'b0;
                    end else begin
                        if (move_l) begin
                            face_d = 1'b0;
                        end else if (move_r) begin
                            face_d = 1'b1;
                        end
`ifdef QUEUE_WRAP_EN
                        if (x_cand < X_MIN_S) begin
                            pos_x_d = XW'(X_MAX);
                        end else if (x_cand > X_MAX_S) begin
                            pos_x_d = XW'(X_MIN);
                        end else begin
                            pos_x_d = XW'(x_cand);
                        end
`else
                        if (x_cand < X_MIN_S) begin
                            pos_x_d = XW'(X_MIN);
                        end else if (x_cand > X_MAX_S) begin
                            pos_x_d = XW'(X_MAX);
                        end else begin
                            pos_x_d = XW'(x_cand);
                        end
`endif
                        case (motion_q)
                            M_GROUND: begin
                                if (btn_jump && jump_armed_q) begin
                                    vy_d         = JUMP_V_S;
                                    motion_d     = M_RISING;
                                    in_air_d     = 1'b1;
                                    jump_armed_d = 1'b0;
                                end
                            end
                            default: begin
                                if (y_next < Y_MIN_S) begin
                                    pos_y_d  = YW'(Y_MIN);
                                    vy_d     = '0;
                                    motion_d = M_FALLING;
                                end else if (y_next >= FLOOR_Y_S) begin
                                    pos_y_d  = YW'(FLOOR_Y);
                                    vy_d     = '0;
                                    motion_d = M_GROUND;
                                    in_air_d = 1'b0;
                                end else begin
                                    pos_y_d  = YW'(y_next);
                                    vy_d     = vy_new;
                                    motion_d = (vy_new > VY_ZERO) ? M_RISING : M_FALLING;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            game_q       <= G_INITIAL;
            motion_q     <= M_GROUND;
            pos_x_q      <= XW'(START_X);
            pos_y_q      <= YW'(FLOOR_Y);
            vy_q         <= '0;
            face_q       <= 1'b1;
            in_air_q     <= 1'b0;
            start_pend_q <= 1'b0;
            go_pend_q    <= 1'b0;
            jump_armed_q <= 1'b1;
        end else begin
            game_q       <= game_d;
            motion_q     <= motion_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vy_q         <= vy_d;
            face_q       <= face_d;
            in_air_q     <= in_air_d;
            start_pend_q <= start_pend_d;
            go_pend_q    <= go_pend_d;
            jump_armed_q <= jump_armed_d;
        end
    end

    assign posX            = pos_x_q;
    assign posY            = pos_y_q;
    assign state           = game_q;
    assign animation_state = face_q;
    assign in_air          = in_air_q;

endmodule

// File: tb/tb_queue_motion.sv
// Directed testbench for queue_motion: reset, start, walking with edge limits,
// jump arc, held-jump rearming, reset mid-jump, game_over and tick-coincident pulses.
module tb_queue_motion;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       game_over;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] posX;
    logic [8:0] posY;
    logic       state;
    logic       animation_state;
    logic       in_air;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_x;

    queue_motion dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .start           (start),
        .game_over       (game_over),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_jump        (btn_jump),
        .posX            (posX),
        .posY            (posY),
        .state           (state),
        .animation_state (animation_state),
        .in_air          (in_air)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle frame_tick; outputs are sampled on the falling edge after it
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (posX !== 10'd320) $display("FAIL reset_posX: got %0d expected 320", posX); else pass_cnt++;
        chk_cnt++; if (posY !== 9'd429) $display("FAIL reset_posY: got %0d expected 429", posY); else pass_cnt++;
        chk_cnt++; if (state !== 1'b0) $display("FAIL reset_state: got %0d expected 0", state); else pass_cnt++;
        chk_cnt++; if (animation_state !== 1'b1) $display("FAIL reset_anim: got %0d expected 1", animation_state); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL reset_in_air: got %0d expected 0", in_air); else pass_cnt++;
        btn_left = 1'b1;
        btn_jump = 1'b1;
        repeat (2) do_tick();
        btn_left = 1'b0;
        btn_jump = 1'b0;
        chk_cnt++; if (posX !== 10'd320) $display("FAIL initial_ignores_btn_posX: got %0d expected 320", posX); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL initial_ignores_btn_in_air: got %0d expected 0", in_air); else pass_cnt++;
    endtask

    task automatic test_start();
        pulse_start();
        repeat (3) @(negedge clk);
        chk_cnt++; if (state !== 1'b0) $display("FAIL start_before_tick: got %0d expected 0", state); else pass_cnt++;
        do_tick();
        chk_cnt++; if (state !== 1'b1) $display("FAIL start_state: got %0d expected 1", state); else pass_cnt++;
        chk_cnt++; if (posX !== 10'd320) $display("FAIL start_posX: got %0d expected 320", posX); else pass_cnt++;
        chk_cnt++; if (posY !== 9'd429) $display("FAIL start_posY: got %0d expected 429", posY); else pass_cnt++;
        chk_cnt++; if (animation_state !== 1'b1) $display("FAIL start_anim: got %0d expected 1", animation_state); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL start_in_air: got %0d expected 0", in_air); else pass_cnt++;
    endtask

    task automatic test_walk();
        btn_left = 1'b1;
        repeat (10) do_tick();
        btn_left = 1'b0;
        chk_cnt++; if (posX !== 10'd300) $display("FAIL walk_left_posX: got %0d expected 300", posX); else pass_cnt++;
        chk_cnt++; if (animation_state !== 1'b0) $display("FAIL walk_left_anim: got %0d expected 0", animation_state); else pass_cnt++;
        btn_right = 1'b1;
        do_tick();
        btn_right = 1'b0;
        chk_cnt++; if (posX !== 10'd302) $display("FAIL walk_right_posX: got %0d expected 302", posX); else pass_cnt++;
        chk_cnt++; if (animation_state !== 1'b1) $display("FAIL walk_right_anim: got %0d expected 1", animation_state); else pass_cnt++;
        // 302 -> 34 takes 134 left steps
        btn_left = 1'b1;
        repeat (134) do_tick();
        chk_cnt++; if (posX !== 10'd34) $display("FAIL walk_to_34: got %0d expected 34", posX); else pass_cnt++;
        do_tick();
        chk_cnt++; if (posX !== 10'd32) $display("FAIL edge_tick1: got %0d expected 32", posX); else pass_cnt++;
        do_tick();
        chk_cnt++; if (posX !== 10'd30) $display("FAIL edge_tick2: got %0d expected 30", posX); else pass_cnt++;
        do_tick();
        btn_left = 1'b0;
`ifdef QUEUE_WRAP_EN
        exp_x = 609;
`else
        exp_x = 30;
`endif
        chk_cnt++; if (posX !== 10'(exp_x)) $display("FAIL edge_tick3: got %0d expected %0d", posX, exp_x); else pass_cnt++;
    endtask

    task automatic test_both_buttons();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        repeat (3) do_tick();
        btn_left  = 1'b0;
        btn_right = 1'b0;
        chk_cnt++; if (posX !== 10'(exp_x)) $display("FAIL both_btn_posX: got %0d expected %0d", posX, exp_x); else pass_cnt++;
        chk_cnt++; if (animation_state !== 1'b0) $display("FAIL both_btn_anim: got %0d expected 0", animation_state); else pass_cnt++;
    endtask

    task automatic test_jump();
        btn_jump = 1'b1;
        do_tick();
        btn_jump = 1'b0;
        chk_cnt++; if (in_air !== 1'b1) $display("FAIL launch_in_air: got %0d expected 1", in_air); else pass_cnt++;
        chk_cnt++; if (posY !== 9'd429) $display("FAIL launch_posY: got %0d expected 429", posY); else pass_cnt++;
        for (int i = 1; i <= 25; i++) begin
            do_tick();
            if (i == 1) begin
                chk_cnt++; if (posY !== 9'd417) $display("FAIL jump_t1_posY: got %0d expected 417", posY); else pass_cnt++;
            end
            if (i == 12 || i == 13) begin
                chk_cnt++; if (posY !== 9'd351) $display("FAIL jump_apex_t%0d_posY: got %0d expected 351", i, posY); else pass_cnt++;
            end
            if (i == 24) begin
                chk_cnt++; if (posY !== 9'd417) $display("FAIL jump_t24_posY: got %0d expected 417", posY); else pass_cnt++;
                chk_cnt++; if (in_air !== 1'b1) $display("FAIL jump_t24_in_air: got %0d expected 1", in_air); else pass_cnt++;
            end
        end
        chk_cnt++; if (posY !== 9'd429) $display("FAIL land_posY: got %0d expected 429", posY); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL land_in_air: got %0d expected 0", in_air); else pass_cnt++;
    endtask

    task automatic test_held_jump();
        int   launches;
        logic prev;
        launches = 0;
        prev     = in_air;
        btn_jump = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_tick();
            if (in_air && !prev) launches++;
            prev = in_air;
        end
        chk_cnt++; if (launches !== 1) $display("FAIL held_jump_launches: got %0d expected 1", launches); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL held_jump_end_in_air: got %0d expected 0", in_air); else pass_cnt++;
        btn_jump = 1'b0;
        do_tick();
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL release_tick_in_air: got %0d expected 0", in_air); else pass_cnt++;
        btn_jump = 1'b1;
        do_tick();
        btn_jump = 1'b0;
        chk_cnt++; if (in_air !== 1'b1) $display("FAIL rearmed_launch: got %0d expected 1", in_air); else pass_cnt++;
        repeat (25) do_tick();
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL rearmed_land_in_air: got %0d expected 0", in_air); else pass_cnt++;
        chk_cnt++; if (posY !== 9'd429) $display("FAIL rearmed_land_posY: got %0d expected 429", posY); else pass_cnt++;
    endtask

    task automatic test_reset_mid_jump();
        btn_jump = 1'b1;
        do_tick();
        btn_jump = 1'b0;
        repeat (4) do_tick();
        chk_cnt++; if (posY !== 9'd387) $display("FAIL mid_jump_posY: got %0d expected 387", posY); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_cnt++; if (posX !== 10'd320) $display("FAIL midrst_posX: got %0d expected 320", posX); else pass_cnt++;
        chk_cnt++; if (posY !== 9'd429) $display("FAIL midrst_posY: got %0d expected 429", posY); else pass_cnt++;
        chk_cnt++; if (state !== 1'b0) $display("FAIL midrst_state: got %0d expected 0", state); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL midrst_in_air: got %0d expected 0", in_air); else pass_cnt++;
        btn_left = 1'b1;
        btn_jump = 1'b1;
        repeat (3) do_tick();
        btn_left = 1'b0;
        btn_jump = 1'b0;
        chk_cnt++; if (posX !== 10'd320) $display("FAIL midrst_hold_posX: got %0d expected 320", posX); else pass_cnt++;
        chk_cnt++; if (posY !== 9'd429) $display("FAIL midrst_hold_posY: got %0d expected 429", posY); else pass_cnt++;
    endtask

    task automatic test_game_over();
        pulse_start();
        do_tick();
        chk_cnt++; if (state !== 1'b1) $display("FAIL restart_state: got %0d expected 1", state); else pass_cnt++;
        btn_right = 1'b1;
        do_tick();
        btn_right = 1'b0;
        chk_cnt++; if (posX !== 10'd322) $display("FAIL pre_go_posX: got %0d expected 322", posX); else pass_cnt++;
        @(negedge clk);
        start     = 1'b1;
        game_over = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        game_over = 1'b0;
        do_tick();
        chk_cnt++; if (state !== 1'b0) $display("FAIL go_wins_state: got %0d expected 0", state); else pass_cnt++;
        chk_cnt++; if (posX !== 10'd322) $display("FAIL go_hold_posX: got %0d expected 322", posX); else pass_cnt++;
        chk_cnt++; if (in_air !== 1'b0) $display("FAIL go_in_air: got %0d expected 0", in_air); else pass_cnt++;
    endtask

    task automatic test_pulse_on_tick();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        start      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        frame_tick = 1'b0;
        chk_cnt++; if (state !== 1'b0) $display("FAIL start_on_tick_same: got %0d expected 0", state); else pass_cnt++;
        do_tick();
        chk_cnt++; if (state !== 1'b1) $display("FAIL start_on_tick_next: got %0d expected 1", state); else pass_cnt++;
        @(negedge clk);
        game_over  = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        game_over  = 1'b0;
        frame_tick = 1'b0;
        chk_cnt++; if (state !== 1'b1) $display("FAIL go_on_tick_same: got %0d expected 1", state); else pass_cnt++;
        do_tick();
        chk_cnt++; if (state !== 1'b0) $display("FAIL go_on_tick_next: got %0d expected 0", state); else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        game_over  = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_jump   = 1'b0;
        exp_x      = 0;
        test_reset();
        test_start();
        test_walk();
        test_both_buttons();
        test_jump();
        test_held_jump();
        test_reset_mid_jump();
        test_game_over();
        test_pulse_on_tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
